pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MDU_LATENCY, default 32, mul/div cycles from issue to result (legal range 2..63).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs id_rs, id_rt  in  5 each  ID-stage source register addresses.
REQ-005 SHALL have inputs id_uses_rs, id_uses_rt, id_uses_hilo, id_is_mdu  in  1 each  ID-stage decode flags.
REQ-006 SHALL have inputs ex_mem_read  in  1  and ex_reg_addr  in  5  load in EX and its destination.
REQ-007 SHALL have inputs ex_branch_taken  in  1  (redirect resolved in EX) and mem_wait  in  1  (data memory not ready).
REQ-008 SHALL have outputs pc_en, if_id_en, id_ex_flush, if_id_flush, ex_mem_en, mem_wb_en  out  1 each  stage controls.
REQ-009 SHALL have outputs mdu_busy  out  1  and mdu_done  out  1  (one-cycle result-valid pulse).

Function
REQ-010 SHALL implement FSM states RUN and MDU_BUSY plus a 6-bit down-counter.
REQ-011 SHALL detect load-use when ex_mem_read=1, ex_reg_addr!=0, and ex_reg_addr matches id_rs with id_uses_rs=1 or id_rt with id_uses_rt=1.
REQ-012 SHALL on load-use drive pc_en=0, if_id_en=0, id_ex_flush=1 in the same cycle; one bubble only.
REQ-013 SHALL in RUN with id_is_mdu=1 and no higher-priority condition enter MDU_BUSY next edge, loading counter with MDU_LATENCY-1.
REQ-014 SHALL in MDU_BUSY decrement counter each non-frozen cycle; at counter=0 pulse mdu_done=1 for that cycle and return to RUN next edge.
REQ-015 SHALL in MDU_BUSY stall (pc_en=0, if_id_en=0, id_ex_flush=1) when id_uses_hilo=1 or id_is_mdu=1; independent instructions proceed.
REQ-016 SHALL hold mdu_busy=1 exactly while state is MDU_BUSY.
REQ-017 SHALL on ex_branch_taken=1 drive if_id_flush=1, id_ex_flush=1, pc_en=1; this overrides load-use and MDU stalls; a flushed id_is_mdu SHALL NOT issue.
REQ-018 SHALL on mem_wait=1 drive all enables 0 and all flushes 0, freezing FSM and counter; highest priority.
REQ-019 SHALL priority: mem_wait > ex_branch_taken > MDU stall > load-use > normal (all enables 1, flushes 0).
REQ-020 SHALL generate all outputs combinationally from registered state and current inputs; zero added latency.

Reset
REQ-021 SHALL on rst=1 force state RUN, counter 0, mdu_busy=0, mdu_done=0 immediately, without clk.
REQ-022 SHALL while rst=1 drive pc_en, if_id_en, ex_mem_en, mem_wb_en=0 and both flushes 0.
REQ-023 SHALL abandon an in-flight MDU operation on reset mid-operation; no mdu_done is issued for it.

Configuration
REQ-024 SHALL with macro PIPE_CTRL_PERF_EN defined add outputs stall_cycles and flush_count (32 bits each, wrap-around, cleared by rst) counting cycles with pc_en=0 and cycles with if_id_flush=1.
REQ-025 SHALL without PIPE_CTRL_PERF_EN omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-026 SHALL place the state enum, counter width constant and register-zero constant in package pipe_ctrl_pkg.
REQ-027 SHALL implement the counter as sub-module mdu_timer (load, enable, zero flag).

Verification
REQ-028 SHALL cover load-use: ex_mem_read=1, ex_reg_addr=5, id_rs=5, id_uses_rs=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_reg_addr=0 -> no stall.
REQ-029 SHALL cover MDU: MDU_LATENCY=4, id_is_mdu pulse at cycle 0 -> mdu_busy cycles 1-4, mdu_done at cycle 4 only; id_uses_hilo at cycle 2 stalls through cycle 4.
REQ-030 SHALL cover branch vs stall: ex_branch_taken=1 with load-use active -> pc_en=1, both flushes 1.
REQ-031 SHALL cover mem_wait=1 for 3 cycles during MDU_BUSY -> all enables 0, mdu_done delayed exactly 3 cycles.
REQ-032 SHALL cover rst asserted mid-MDU (counter=2) -> mdu_busy=0 asynchronously, no mdu_done after release.
REQ-033 SHALL cover PIPE_CTRL_PERF_EN build: 2 load-use stalls plus 1 branch -> stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun,
    StMduBusy
  } state_e;

  localparam int unsigned MduCntW = 6;
  localparam logic [4:0] RegZero  = 5'd0;

endpackage

// File: rtl/pipe_ctrl_mdu_timer.sv
// Loadable down-counter timing an in-flight mul/div operation.
module mdu_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with load-use, mul/div and branch handling.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / flush_count counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_uses_hilo,
  input  logic        id_is_mdu,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_reg_addr,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_flush,
  output logic        if_id_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        mdu_busy,
  output logic        mdu_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [MduCntW-1:0] LoadVal = MduCntW'(MDU_LATENCY - 1);

  state_e state;
  logic   busy, load_use, hilo_stall, issue, cnt_zero;

  assign busy = (state == StMduBusy);

  assign load_use = ex_mem_read && (ex_reg_addr != RegZero) &&
                    ((id_uses_rs && (id_rs == ex_reg_addr)) ||
                     (id_uses_rt && (id_rt == ex_reg_addr)));

  assign hilo_stall = busy && (id_uses_hilo || id_is_mdu);

  // A stalled or flushed mul/div must not start; it retries from ID.
  assign issue = !busy && id_is_mdu && !mem_wait && !ex_branch_taken && !load_use;

  mdu_timer #(
    .Width (MduCntW)
  ) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .load_val (LoadVal),
    .en       (busy && !mem_wait && !cnt_zero),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StRun;
    end else if (!mem_wait) begin
      case (state)
        StRun:     if (issue) state <= StMduBusy;
        StMduBusy: if (cnt_zero) state <= StRun;
        default:   state <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    id_ex_flush = 1'b0;
    if_id_flush = 1'b0;
    if (rst || mem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_branch_taken) begin
      id_ex_flush = 1'b1;
      if_id_flush = 1'b1;
    end else if (hilo_stall || load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mdu_busy = busy;
  // Suppressed while frozen so a memory wait delays the pulse instead of stretching it.
  assign mdu_done = busy && cnt_zero && !mem_wait && !rst;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(!pc_en);
      flush_count  <= flush_count + 32'(if_id_flush);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int Lat = 4;

  logic       clk, rst;
  logic [4:0] id_rs, id_rt, ex_reg_addr;
  logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_is_mdu;
  logic       ex_mem_read, ex_branch_taken, mem_wait;
  logic       pc_en, if_id_en, id_ex_flush, if_id_flush, ex_mem_en, mem_wb_en;
  logic       mdu_busy, mdu_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int errors = 0;
  int checks = 0;
  // Model: unfrozen busy cycles left for the current mul/div (0 = idle).
  int mdu_left = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  pipe_ctrl #(
    .MDU_LATENCY (Lat)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_uses_hilo    (id_uses_hilo),
    .id_is_mdu       (id_is_mdu),
    .ex_mem_read     (ex_mem_read),
    .ex_reg_addr     (ex_reg_addr),
    .ex_branch_taken (ex_branch_taken),
    .mem_wait        (mem_wait),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_flush     (id_ex_flush),
    .if_id_flush     (if_id_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .mdu_busy        (mdu_busy),
    .mdu_done        (mdu_done)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_reg_addr = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0; id_is_mdu = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_wait = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(input string tag);
    logic lu, hs, busy;
    logic e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf, e_done;
    @(negedge clk);
    busy = (mdu_left > 0) && !rst;
    lu = ex_mem_read && (ex_reg_addr != 5'd0) &&
         ((id_uses_rs && id_rs == ex_reg_addr) || (id_uses_rt && id_rt == ex_reg_addr));
    hs = busy && (id_uses_hilo || id_is_mdu);
    {e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf} = 6'b111100;
    if (rst || mem_wait)          {e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf} = 6'b000000;
    else if (ex_branch_taken)     {e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf} = 6'b111111;
    else if (hs || lu)            {e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf} = 6'b001101;
    e_done = busy && (mdu_left == 1) && !mem_wait;
    chk1({tag, ".pc_en"}, pc_en, e_pc);
    chk1({tag, ".if_id_en"}, if_id_en, e_ifid);
    chk1({tag, ".ex_mem_en"}, ex_mem_en, e_exmem);
    chk1({tag, ".mem_wb_en"}, mem_wb_en, e_memwb);
    chk1({tag, ".if_id_flush"}, if_id_flush, e_iff);
    chk1({tag, ".id_ex_flush"}, id_ex_flush, e_idf);
    chk1({tag, ".mdu_busy"}, mdu_busy, busy);
    chk1({tag, ".mdu_done"}, mdu_done, e_done);
`ifdef PIPE_CTRL_PERF_EN
    chk32({tag, ".stall_cycles"}, stall_cycles, m_stall);
    chk32({tag, ".flush_count"}, flush_count, m_flush);
`endif
    @(posedge clk);
    if (rst) begin
      mdu_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall += int'(!e_pc);
      m_flush += int'(e_iff);
      if (!mem_wait) begin
        if (busy) mdu_left--;
        else if (id_is_mdu && !ex_branch_taken && !lu) mdu_left = Lat;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle");

    // Load-use bubble, then the same match against r0 must not stall.
    ex_mem_read = 1'b1; ex_reg_addr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    step("loaduse");
    idle();
    step("loaduse_after");
    ex_mem_read = 1'b1; ex_reg_addr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    step("loaduse_r0");
    idle();

    // MDU issue with a HI/LO reader arriving at cycle 2.
    id_is_mdu = 1'b1;
    step("mdu_c0");
    idle();
    step("mdu_c1");
    id_uses_hilo = 1'b1;
    step("mdu_c2");
    step("mdu_c3");
    step("mdu_c4");
    step("mdu_c5");
    idle();

    // Branch overrides an active load-use.
    ex_mem_read = 1'b1; ex_reg_addr = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    ex_branch_taken = 1'b1;
    step("branch_lu");
    idle();

    // Memory wait for 3 cycles in the middle of an MDU operation.
    id_is_mdu = 1'b1;
    step("mw_issue");
    idle();
    step("mw_b1");
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) step("mw_frozen");
    mem_wait = 1'b0;
    for (int i = 0; i < 5; i++) step("mw_resume");

    // Asynchronous reset while the counter holds 2.
    id_is_mdu = 1'b1;
    step("ar_issue");
    idle();
    step("ar_b1");
    #2 rst = 1'b1;
    #1;
    chk1("async_rst.mdu_busy", mdu_busy, 1'b0);
    chk1("async_rst.mdu_done", mdu_done, 1'b0);
    chk1("async_rst.pc_en", pc_en, 1'b0);
    mdu_left = 0; m_stall = 0; m_flush = 0;
    step("ar_held");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step("ar_after");

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b1;
    step("perf_rst");
    rst = 1'b0;
    ex_mem_read = 1'b1; ex_reg_addr = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    step("perf_lu1");
    idle();
    step("perf_gap");
    ex_mem_read = 1'b1; ex_reg_addr = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("perf_lu2");
    idle();
    ex_branch_taken = 1'b1;
    step("perf_br");
    idle();
    @(negedge clk);
    chk32("perf.stall_cycles", stall_cycles, 32'd2);
    chk32("perf.flush_count", flush_count, 32'd1);
`endif

    // Random traffic with small register addresses to provoke matches.
    for (int i = 0; i < 400; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_reg_addr     = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_uses_hilo    = ($urandom_range(0, 4) == 0);
      id_is_mdu       = ($urandom_range(0, 3) == 0);
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_wait        = ($urandom_range(0, 4) == 0);
      step("rand");
    end
    idle();
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
